// File: rtl/uart_rx.sv
// uart_rx -- 8-bit serial receiver, frame: start(0), 8 data LSB first,
// parity, stop(1). Rx is synchronized and sampled at bit centres using a
// bit-timer, and the received frame is held until it is acknowledged.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   Rx         serial line, idles high, asynchronous to clk
//   DataOut    last received data byte
//   ParityBit  parity bit of the last received frame, as sampled
//   data_valid unconsumed frame held on DataOut/ParityBit/flags
//   data_ack   consumer accepts the current frame
//   parity_err even-parity mismatch on the current frame
//   frame_err  stop bit sampled low on the current frame
//   overrun    sticky: a frame was dropped while data_valid was high
//   busy       receiver is not idle
//
// Optional feature: define UART_RX_PARITY_CHECK_EN to enable the parity
// check. Without it parity_err is tied low; ParityBit is still reported.
//
// state  | meaning
// IDLE   | waiting for a low level on the synchronized line
// START  | timing to the middle of the start bit to reject glitches
// DATA   | sampling the 8 data bits at their centres
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then handing the frame over
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rx,
  output logic [7:0] DataOut,
  output logic       ParityBit,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_nxt;
  logic [1:0]    sync;
  logic          rxs;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          par_reg;
  logic          timer_clr, shift_en, par_en, stop_en;
  logic          load;

  // Synchronizer flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b11;
    else        sync <= {sync[0], Rx};
  end
  assign rxs = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    stop_en   = 1'b0;
    case (state)
      S_IDLE: begin
        timer_clr = 1'b1;
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        if (timer == HALF_END) begin
          timer_clr = 1'b1;
          state_nxt = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (timer == BIT_END) begin
          timer_clr = 1'b1;
          shift_en  = 1'b1;
          if (bit_idx == 3'd7) state_nxt = S_PARITY;
        end
      end
      S_PARITY: begin
        if (timer == BIT_END) begin
          timer_clr = 1'b1;
          par_en    = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (timer == BIT_END) begin
          timer_clr = 1'b1;
          stop_en   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        timer_clr = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy = (state != S_IDLE);

  // Timer clears on every sample point, so it never reaches a wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         timer <= '0;
    else if (timer_clr) timer <= '0;
    else                timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
      par_reg   <= 1'b0;
    end else begin
      if (state == S_START) bit_idx <= 3'd0;
      else if (shift_en)    bit_idx <= bit_idx + 3'd1;
      if (shift_en) shift_reg <= {rxs, shift_reg[7:1]};
      if (par_en)   par_reg   <= rxs;
    end
  end

  // An ack in the same cycle as the stop sample frees the slot for the new frame.
  assign load = stop_en && (!data_valid || data_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DataOut    <= 8'h00;
      ParityBit  <= 1'b0;
      frame_err  <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (load) begin
        DataOut    <= shift_reg;
        ParityBit  <= par_reg;
        frame_err  <= ~rxs;
        data_valid <= 1'b1;
      end else if (stop_en) begin
        overrun    <= 1'b1;
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  logic perr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    perr_q <= 1'b0;
    else if (load) perr_q <= (^shift_reg) != par_reg;
  end
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed and random frames for uart_rx, checked against a
// frame-level model of what the consumer should see.
module tb_uart_rx;

  localparam int CPB = 16;
  // Start edge to data_valid: 2 synchronizer flops, 1 idle detect,
  // half a bit of start, 10 full bits (8 data, parity, stop).
  localparam int LAT = 2 + 1 + CPB / 2 + 10 * CPB;
`ifdef UART_RX_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       Rx = 1'b1;
  logic       data_ack = 1'b0;
  logic [7:0] DataOut;
  logic       ParityBit, data_valid, parity_err, frame_err, overrun, busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .Rx(Rx), .DataOut(DataOut),
    .ParityBit(ParityBit), .data_valid(data_valid), .data_ack(data_ack),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  logic       m_valid, m_par, m_perr, m_ferr, m_ovr;
  logic [7:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = 8'h00; m_par = 0; m_perr = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic model_frame(input logic [7:0] d, input logic p, input logic s, input bit acked);
    if (!m_valid || acked) begin
      m_valid = 1;
      m_data  = d;
      m_par   = p;
      m_perr  = PCHK ? ((^d) != p) : 1'b0;
      m_ferr  = ~s;
    end else begin
      m_ovr = 1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, data_valid, m_valid);
    check({tag, ".data"}, DataOut, m_data);
    check({tag, ".parbit"}, ParityBit, m_par);
    check({tag, ".perr"}, parity_err, m_perr);
    check({tag, ".ferr"}, frame_err, m_ferr);
    check({tag, ".ovr"}, overrun, m_ovr);
  endtask

  task automatic do_ack(input string tag);
    data_ack = 1;
    cyc();
    data_ack = 0;
    m_valid = 0;
    check({tag, ".ack"}, data_valid, 1'b0);
  endtask

  // Drives one frame; ack_at / abort_at are cycle numbers from the start
  // edge (0 = unused). abort_at drops rst_n and ends the frame early.
  task automatic send(input logic [7:0] d, input logic p, input logic s,
                      input int ack_at, input int abort_at, output int rise);
    logic [10:0] bits;
    int cnt;
    bit was_valid;
    bits = {s, p, d, 1'b0};
    cnt = 0;
    rise = -1;
    was_valid = data_valid;
    for (int j = 0; j < 11; j++) begin
      Rx = bits[j];
      for (int k = 0; k < CPB; k++) begin
        cyc();
        cnt++;
        if (!was_valid && rise < 0 && data_valid) rise = cnt;
        if (cnt == ack_at) data_ack = 1;
        if (cnt == ack_at + 1) data_ack = 0;
        if (cnt == abort_at) begin
          rst_n = 0;
          Rx = 1;
          #1;
          return;
        end
      end
    end
    Rx = 1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 0;
    repeat (3) cyc();
    model_reset();
    check_outputs(tag);
    check({tag, ".busy"}, busy, 1'b0);
    rst_n = 1;
    repeat (3) cyc();
  endtask

  int rise;
  logic [7:0] rd;
  logic rp;

  initial begin
    model_reset();
    do_reset("reset");

    // Nominal frame and latency to data_valid.
    send(8'hA5, 1'b0, 1'b1, 0, 0, rise);
    check("a5.latency", rise, LAT);
    model_frame(8'hA5, 1'b0, 1'b1, 0);
    check_outputs("a5");
    do_ack("a5");
    data_ack = 1;
    cyc();
    data_ack = 0;
    check("idle_ack.valid", data_valid, 1'b0);
    repeat (5) cyc();

    // Odd data with parity 0.
    send(8'h01, 1'b0, 1'b1, 0, 0, rise);
    model_frame(8'h01, 1'b0, 1'b1, 0);
    check_outputs("par01");
    do_ack("par01");
    repeat (5) cyc();

    // Framing error, then a good frame after the line recovers.
    send(8'h3C, 1'b0, 1'b0, 0, 0, rise);
    model_frame(8'h3C, 1'b0, 1'b0, 0);
    check_outputs("ferr3c");
    do_ack("ferr3c");
    repeat (40) cyc();
    check("ferr3c.busy", busy, 1'b0);
    send(8'h55, 1'b0, 1'b1, 0, 0, rise);
    model_frame(8'h55, 1'b0, 1'b1, 0);
    check_outputs("good55");
    do_ack("good55");
    repeat (5) cyc();

    // 6-cycle glitch is rejected at the start-bit midpoint.
    Rx = 0;
    repeat (6) cyc();
    Rx = 1;
    check("glitch.busy_hi", busy, 1'b1);
    repeat (20) cyc();
    check("glitch.busy_lo", busy, 1'b0);
    check("glitch.valid", data_valid, 1'b0);

    // Back-to-back without ack: second frame dropped.
    send(8'h11, 1'b0, 1'b1, 0, 0, rise);
    model_frame(8'h11, 1'b0, 1'b1, 0);
    send(8'h22, 1'b0, 1'b1, 0, 0, rise);
    model_frame(8'h22, 1'b0, 1'b1, 0);
    check_outputs("ovr");
    do_ack("ovr");
    do_reset("ovr_reset");

    // Back-to-back with ack on the stop-sample cycle: second frame loads.
    send(8'h11, 1'b0, 1'b1, 0, 0, rise);
    model_frame(8'h11, 1'b0, 1'b1, 0);
    send(8'h22, 1'b0, 1'b1, LAT - 1, 0, rise);
    model_frame(8'h22, 1'b0, 1'b1, 1);
    check_outputs("ack_stop");
    do_ack("ack_stop");
    repeat (5) cyc();

    // Reset during data bit 4 with a frame already held.
    send(8'h9E, 1'b1, 1'b1, 0, 0, rise);
    model_frame(8'h9E, 1'b1, 1'b1, 0);
    check_outputs("held9e");
    send(8'h77, 1'b0, 1'b1, 0, 5 * CPB + 6, rise);
    model_reset();
    check_outputs("rst_mid");
    check("rst_mid.busy", busy, 1'b0);
    repeat (3) cyc();
    rst_n = 1;
    repeat (10) cyc();
    send(8'hF0, 1'b0, 1'b1, 0, 0, rise);
    model_frame(8'hF0, 1'b0, 1'b1, 0);
    check_outputs("f0");
    do_ack("f0");

    // Random frames with random parity bits.
    for (int i = 0; i < 8; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 10)) cyc();
      send(rd, rp, 1'b1, 0, 0, rise);
      model_frame(rd, rp, 1'b1, 0);
      check_outputs($sformatf("rnd%0d", i));
      do_ack($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
